// File: rtl/pc_pkg.sv
// Shared definitions for the program counter: default width, next-PC select
// encodings and the sequential increment step.
package pc_pkg;

  localparam int unsigned PC_BITS_DEFAULT = 6;
  localparam int unsigned PC_INCR         = 2;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_HOLD   = 2'b11;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: increment, PC-relative branch, absolute jump or hold.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int unsigned PC_BITS = PC_BITS_DEFAULT
) (
  input  logic [PC_BITS-1:0] pc,
  input  logic [1:0]         pc_ctl,
  input  logic [PC_BITS-1:0] imm,
  input  logic [PC_BITS-1:0] sr1_val,
  output logic [PC_BITS-1:0] next_pc_c
);

  // Sums are kept at PC_BITS so carries drop out and addresses wrap naturally.
  always_comb begin
    next_pc_c = pc;
    case (pc_ctl)
      PC_INC:    next_pc_c = pc + PC_BITS'(PC_INCR);
      PC_BRANCH: next_pc_c = pc + imm;
      PC_JUMP:   next_pc_c = sr1_val;
      default:   next_pc_c = pc;
    endcase
  end

endmodule

// File: rtl/pc.sv
// Program counter: one register loaded from the next-PC mux on enabled edges,
// cleared asynchronously by an active-low reset.
module pc
  import pc_pkg::*;
#(
  parameter int unsigned PC_BITS = PC_BITS_DEFAULT
) (
  input  logic               clka,
  input  logic               reset,
  input  logic               pc_latch_data,
  input  logic [1:0]         pc_ctl,
  input  logic [PC_BITS-1:0] imm,
  input  logic [PC_BITS-1:0] sr1_val,
  output logic [PC_BITS-1:0] pc_out
);

  logic [PC_BITS-1:0] next_pc_c;

  pc_next_mux #(
    .PC_BITS (PC_BITS)
  ) u_next_mux (
    .pc        (pc_out),
    .pc_ctl    (pc_ctl),
    .imm       (imm),
    .sr1_val   (sr1_val),
    .next_pc_c (next_pc_c)
  );

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      pc_out <= '0;
    end else if (pc_latch_data) begin
      pc_out <= next_pc_c;
    end
  end

endmodule

// File: tb/tb_pc.sv
// Randomized scoreboard bench for the program counter against an arithmetic reference model.
module tb_pc;

  localparam int unsigned PC_BITS = 6;
  localparam int          MODULUS = 1 << PC_BITS;

  logic               clka;
  logic               reset;
  logic               pc_latch_data;
  logic [1:0]         pc_ctl;
  logic [PC_BITS-1:0] imm;
  logic [PC_BITS-1:0] sr1_val;
  logic [PC_BITS-1:0] pc_out;

  int n_cmp;
  int n_err;
  int model_pc;
  int exp_q[$];
  event chk_ev;

  pc #(
    .PC_BITS (PC_BITS)
  ) dut (
    .clka          (clka),
    .reset         (reset),
    .pc_latch_data (pc_latch_data),
    .pc_ctl        (pc_ctl),
    .imm           (imm),
    .sr1_val       (sr1_val),
    .pc_out        (pc_out)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Monitor: compares on every falling edge, or immediately when asked (async reset checks).
  initial begin
    n_cmp = 0;
    n_err = 0;
    forever begin
      @(negedge clka or chk_ev);
      while (exp_q.size() > 0) begin
        int e;
        e = exp_q.pop_front();
        n_cmp++;
        if (int'(pc_out) !== e) begin
          n_err++;
          $display("FAIL pc_out at %0t: got %0d expected %0d", $time, pc_out, e);
        end
      end
    end
  end

  // Reference behaviour straight from the rules: modular arithmetic on integers.
  function automatic int model_next(int cur, logic latch, logic [1:0] ctl,
                                    logic [PC_BITS-1:0] off, logic [PC_BITS-1:0] tgt);
    int s;
    if (!latch) return cur;
    case (ctl)
      2'd0: return (cur + 2) % MODULUS;
      2'd1: begin
        s = (int'(off) >= MODULUS / 2) ? int'(off) - MODULUS : int'(off);
        return ((cur + s) % MODULUS + MODULUS) % MODULUS;
      end
      2'd2: return int'(tgt);
      default: return cur;
    endcase
  endfunction

  // Drive one cycle's inputs, let the edge happen, then queue the expected PC.
  task automatic step(input logic latch, input logic [1:0] ctl,
                      input int off, input int tgt);
    pc_latch_data = latch;
    pc_ctl        = ctl;
    imm           = PC_BITS'(off);
    sr1_val       = PC_BITS'(tgt);
    @(posedge clka);
    #1;
    model_pc = model_next(model_pc, latch, ctl, PC_BITS'(off), PC_BITS'(tgt));
    exp_q.push_back(model_pc);
  endtask

  // Assert reset between edges, check the immediate clear, hold it over an enabled jump edge.
  task automatic do_reset();
    @(negedge clka);
    #2;
    reset = 1'b0;
    #1;
    model_pc = 0;
    exp_q.push_back(0);
    -> chk_ev;
    pc_latch_data = 1'b1;
    pc_ctl        = 2'b10;
    sr1_val       = PC_BITS'(33);
    @(posedge clka);
    #1;
    exp_q.push_back(0);
    @(negedge clka);
    #2;
    reset         = 1'b1;
    pc_latch_data = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    pc_latch_data = 1'b0;
    pc_ctl        = 2'b00;
    imm           = '0;
    sr1_val       = '0;
    model_pc      = 0;
    repeat (2) @(posedge clka);
    #1;
    exp_q.push_back(0);
    @(negedge clka);
    #2;
    reset = 1'b1;

    // Out of reset with no latch: stays at zero.
    repeat (3) step(1'b0, 2'b00, 0, 0);
    // Sequential sweep across the top of the address space.
    repeat (32) step(1'b1, 2'b00, 0, 0);
    // Enable gating.
    repeat (4) step(1'b0, 2'b01, 10, 32);
    // Branches forward and backward.
    step(1'b1, 2'b01, 10, 0);
    step(1'b1, 2'b00, 0, 0);
    step(1'b1, 2'b01, 6'b111100, 0);
    // Jump then increment.
    step(1'b1, 2'b10, 0, 6'b100000);
    step(1'b1, 2'b00, 0, 0);
    // Reserved select holds even when latched.
    step(1'b1, 2'b11, 13, 7);
    // Branch wrap in both directions, odd jump target.
    step(1'b1, 2'b10, 0, 60);
    step(1'b1, 2'b01, 8, 0);
    step(1'b1, 2'b01, 6'b111000, 0);
    step(1'b1, 2'b10, 0, 45);
    step(1'b1, 2'b00, 0, 0);
    // Reset mid-operation with a nonzero PC.
    do_reset();
    step(1'b0, 2'b00, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           int'($urandom_range(0, MODULUS - 1)), int'($urandom_range(0, MODULUS - 1)));
      if (i % 97 == 96) do_reset();
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clka);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc.md
# pc

Program counter for the microprocessor core. Holds the current fetch address and updates it once per instruction under control of the decode/control unit. Supports sequential increment by 2, PC-relative branch by an immediate, and an absolute jump to a register value. Its output drives the instruction-memory address.

## Interface

Parameters:
- PC_BITS, default 6, width of the program counter and of both address operands.

Ports:
- clka  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears the PC.
- pc_latch_data  input  1  update enable; PC changes only on edges where this is 1.
- pc_ctl  input  2  next-PC select: 00 increment, 01 branch, 10 jump, 11 hold.
- imm  input  PC_BITS  branch offset, two's complement.
- sr1_val  input  PC_BITS  absolute jump target from source register 1.
- pc_out  output  PC_BITS  current program counter value (registered).

## Operation

- The PC is one PC_BITS-wide register; pc_out is that register directly, with no combinational path from inputs.
- The next value depends on pc_ctl:
  - 00: pc + 2.
  - 01: pc + imm, where imm is a signed offset relative to the current PC.
  - 10: sr1_val, taken as-is.
  - 11: pc unchanged; reserved, and treated as hold.
- All arithmetic is modulo 2^PC_BITS. Carries are discarded.
- Wrap-around: 2^PC_BITS − 2 + 2 gives 0. A branch past either end also wraps.
- When pc_latch_data = 0, the PC holds regardless of pc_ctl, imm or sr1_val.
- Bit 0 is not forced. Odd targets from imm or sr1_val are accepted unchanged.

## Timing

- Reset:
  - While reset = 0, pc_out = 0 immediately (asynchronous), independent of clka.
  - reset = 0 overrides pc_latch_data.
  - After reset deasserts, the first update happens on the next qualifying clka rising edge.
- Update latency: inputs are sampled on the clka rising edge where pc_latch_data = 1. pc_out shows the new value after that edge, so latency is 1 cycle.
- pc_ctl, imm and sr1_val only need to be stable around the qualifying edge.
- Reset mid-operation: an asynchronous assert clears the PC at once. An update pending on the same edge is discarded.
- Steady-state throughput: one PC update per clock while pc_latch_data is held high. The control unit normally pulses it once per instruction cycle.
- Out of reset, with no updates, pc_out stays 0.

## Structure

- Shared package holds:
  - PC_BITS default;
  - pc_ctl encodings as named constants: PC_INC = 2'b00, PC_BRANCH = 2'b01, PC_JUMP = 2'b10, PC_HOLD = 2'b11;
  - PC increment constant (2).
- One natural sub-module, pc_next_mux: purely combinational next-PC selection (adder plus 4-way mux). The top level holds the register with async active-low reset and the enable.

## Test plan

- Reset: drive reset = 0 mid-cycle with pc_out nonzero, clka idle → pc_out = 0 at once. Release reset, no latch → pc_out stays 0.
- Sequential sweep: pc_ctl = 00, pulse pc_latch_data 32 times (PC_BITS = 6) → pc_out steps 2, 4, …, 62, then 0 (wrap).
- Enable gating: pc_latch_data = 0 for several edges with pc_ctl = 01, imm = 10, sr1_val = 32 → pc_out unchanged.
- Branch: from pc = 0, pc_ctl = 01, imm = 10, one latch → pc_out = 10. Next latch with pc_ctl = 00 → 12. Negative offset: from 12, imm = 6'b111100 (−4) → 8.
- Jump: pc_ctl = 10, sr1_val = 6'b100000, one latch → pc_out = 32. Next latch with pc_ctl = 00 → 34.
- Hold and wrap: pc_ctl = 11 with a latch → unchanged. From pc = 60, branch imm = 8 → pc_out = 4.
